// File: rtl/brake_sequencer.sv
// Per-train brake sequencer: ramps the commanded speed toward the track/driver target and
// runs the brake -> stop -> hold -> resume sequence. Optional feature macro: BRAKE_LATCH_EN.
module brake_sequencer #(
  parameter int DATA_W        = 8,
  parameter int ACCEL_STEP    = 2,
  parameter int DECEL_STEP    = 4,
  parameter int BRAKE_STEP    = 10,
  parameter int CAUTION_SPEED = 20,
  parameter int HOLD_CYCLES   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alert,
  input  logic              brake,
  input  logic [DATA_W-1:0] limit_speed,
  input  logic [DATA_W-1:0] req_speed,
  input  logic              resume,
  output logic [DATA_W-1:0] cmd_speed,
  output logic [2:0]        fsm_state,
  output logic              emergency
);

  localparam int SW    = DATA_W + 2;
  localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;

  typedef logic signed [SW-1:0] wide_t;

  localparam wide_t ACC_S = wide_t'(ACCEL_STEP);
  localparam wide_t DEC_S = wide_t'(DECEL_STEP);
  localparam wide_t BRK_S = wide_t'(BRAKE_STEP);
  localparam logic [DATA_W-1:0] CAUT_V   = DATA_W'(CAUTION_SPEED);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    CRUISE  = 3'd0,
    CAUTION = 3'd1,
    BRAKING = 3'd2,
    STOPPED = 3'd3,
    HOLD    = 3'd4
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   hold_cnt;
  logic [DATA_W-1:0]  target;
  logic [DATA_W-1:0]  caut_target;
  logic [DATA_W-1:0]  brk_speed;
  logic               clear;

  function automatic logic [DATA_W-1:0] min_u(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    min_u = (a < b) ? a : b;
  endfunction

  // Step toward tgt without overshooting it; the extra headroom bits prevent wrap at 0 and max.
  function automatic logic [DATA_W-1:0] ramp_to(input logic [DATA_W-1:0] cur,
                                                 input logic [DATA_W-1:0] tgt);
    wide_t cur_s, tgt_s, up_s, dn_s;
    cur_s = $signed({2'b00, cur});
    tgt_s = $signed({2'b00, tgt});
    up_s  = cur_s + ACC_S;
    dn_s  = cur_s - DEC_S;
    ramp_to = cur;
    if (cur_s < tgt_s)
      ramp_to = (up_s > tgt_s) ? tgt : up_s[DATA_W-1:0];
    else if (cur_s > tgt_s)
      ramp_to = (dn_s < tgt_s) ? tgt : dn_s[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] brake_sat(input logic [DATA_W-1:0] cur);
    wide_t dn_s;
    dn_s = $signed({2'b00, cur}) - BRK_S;
    brake_sat = (dn_s < 0) ? '0 : dn_s[DATA_W-1:0];
  endfunction

  always_comb begin
    target      = min_u(req_speed, limit_speed);
    caut_target = min_u(target, CAUT_V);
    brk_speed   = brake_sat(cmd_speed);
    clear       = !brake && !alert;
  end

  assign fsm_state = state;

`ifndef BRAKE_LATCH_EN
  logic unused_resume;
  assign unused_resume = resume;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CRUISE;
      cmd_speed <= '0;
      emergency <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      case (state)
        CRUISE, CAUTION: begin
          // The transition edge already applies the new state's ramp/brake step.
          if (brake) begin
            cmd_speed <= brk_speed;
            state     <= (brk_speed == '0) ? STOPPED : BRAKING;
            emergency <= 1'b1;
          end else if (alert) begin
            cmd_speed <= ramp_to(cmd_speed, caut_target);
            state     <= CAUTION;
            emergency <= 1'b0;
          end else begin
            cmd_speed <= ramp_to(cmd_speed, target);
            state     <= CRUISE;
            emergency <= 1'b0;
          end
        end
        BRAKING: begin
          cmd_speed <= brk_speed;
          emergency <= 1'b1;
          if (brk_speed == '0)
            state <= STOPPED;
        end
        STOPPED: begin
          cmd_speed <= '0;
          emergency <= 1'b1;
          if (clear) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
        end
        HOLD: begin
          cmd_speed <= '0;
          emergency <= 1'b1;
          if (brake) begin
            state <= STOPPED;
          end else if (alert) begin
            hold_cnt <= '0;
          end else begin
`ifdef BRAKE_LATCH_EN
            // Counter saturates at expiry; only an operator resume releases the hold.
            if (hold_cnt == CNT_LAST) begin
              if (resume) begin
                state     <= CRUISE;
                hold_cnt  <= '0;
                emergency <= 1'b0;
              end
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
`else
            if (hold_cnt + 1'b1 == CNT_LAST) begin
              state     <= CRUISE;
              hold_cnt  <= '0;
              emergency <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
`endif
          end
        end
        default: begin
          state     <= STOPPED;
          cmd_speed <= '0;
          emergency <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_brake_sequencer.sv
// Directed bench for brake_sequencer; covers both builds (BRAKE_LATCH_EN defined or not).
module tb_brake_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       alert;
  logic       brake;
  logic [7:0] limit_speed;
  logic [7:0] req_speed;
  logic       resume;
  logic [7:0] cmd_speed;
  logic [2:0] fsm_state;
  logic       emergency;

  int errors = 0;
  int checks = 0;

  localparam int S_CRUISE = 0, S_CAUTION = 1, S_BRAKING = 2, S_STOPPED = 3, S_HOLD = 4;

  brake_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .alert       (alert),
    .brake       (brake),
    .limit_speed (limit_speed),
    .req_speed   (req_speed),
    .resume      (resume),
    .cmd_speed   (cmd_speed),
    .fsm_state   (fsm_state),
    .emergency   (emergency)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int c, input int s, input int e);
    chk({tag, ".cmd"}, int'(cmd_speed), c);
    chk({tag, ".state"}, int'(fsm_state), s);
    chk({tag, ".emerg"}, int'(emergency), e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; alert = 1'b0; brake = 1'b0; resume = 1'b0;
    req_speed = 8'd60; limit_speed = 8'd40;
    step();
    expect_out("reset", 0, S_CRUISE, 0);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: ramp to min(req, limit) = 40
    for (int i = 1; i <= 20; i++) begin
      step();
      expect_out($sformatf("t1.ramp%0d", i), 2 * i, S_CRUISE, 0);
    end
    step(); step();
    expect_out("t1.hold40", 40, S_CRUISE, 0);

    // Test 2: caution cap, then release
    alert = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      expect_out($sformatf("t2.caut%0d", i), 40 - 4 * i, S_CAUTION, 0);
    end
    step(); step();
    expect_out("t2.caut_hold", 20, S_CAUTION, 0);
    alert = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      expect_out($sformatf("t2.up%0d", i), 20 + 2 * i, S_CRUISE, 0);
    end

    // Test 3: braking from 40
    brake = 1'b1;
    step(); expect_out("t3.b1", 30, S_BRAKING, 1);
    step(); expect_out("t3.b2", 20, S_BRAKING, 1);
    step(); expect_out("t3.b3", 10, S_BRAKING, 1);
    step(); expect_out("t3.b4", 0, S_STOPPED, 1);
    step(); expect_out("t3.stay", 0, S_STOPPED, 1);

    // Test 4: hold, brake pulse at counter=5, then full clear hold
    brake = 1'b0;
    step(); expect_out("t4.hold_in", 0, S_HOLD, 1);
    for (int i = 1; i <= 5; i++) begin
      step();
      expect_out($sformatf("t4.cnt%0d", i), 0, S_HOLD, 1);
    end
    brake = 1'b1;
    step(); expect_out("t4.restop", 0, S_STOPPED, 1);
    brake = 1'b0;
    step(); expect_out("t4.clr1", 0, S_HOLD, 1);
    for (int i = 2; i <= 7; i++) begin
      resume = (i == 4);
      step();
      expect_out($sformatf("t4.clr%0d", i), 0, S_HOLD, 1);
    end
    resume = 1'b0;
    step();
`ifdef BRAKE_LATCH_EN
    expect_out("t6.expired", 0, S_HOLD, 1);
    for (int i = 1; i <= 20; i++) begin
      step();
      expect_out($sformatf("t6.latch%0d", i), 0, S_HOLD, 1);
    end
    resume = 1'b1;
    step();
    resume = 1'b0;
`endif
    expect_out("t4.exit", 0, S_CRUISE, 0);
    step(); expect_out("t4.ramp0", 2, S_CRUISE, 0);

    // Alert in HOLD restarts the count; small cmd brakes straight to STOPPED
    brake = 1'b1;
    step(); expect_out("h.direct_stop", 0, S_STOPPED, 1);
    brake = 1'b0;
    step(); expect_out("h.in", 0, S_HOLD, 1);
    step(); step(); step();
    alert = 1'b1;
    step(); expect_out("h.alert", 0, S_HOLD, 1);
    alert = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      expect_out($sformatf("h.recount%0d", i), 0, S_HOLD, 1);
    end
    step();
`ifdef BRAKE_LATCH_EN
    expect_out("h.latched", 0, S_HOLD, 1);
    resume = 1'b1;
    step();
    resume = 1'b0;
`endif
    expect_out("h.exit", 0, S_CRUISE, 0);

    // Boundary: ramp to 255 without wrap, then limit drop decelerates gradually to 0
    req_speed = 8'd255; limit_speed = 8'd255;
    for (int i = 1; i <= 127; i++) step();
    expect_out("bnd.254", 254, S_CRUISE, 0);
    step(); expect_out("bnd.255", 255, S_CRUISE, 0);
    step(); expect_out("bnd.255hold", 255, S_CRUISE, 0);
    limit_speed = 8'd0;
    step(); expect_out("bnd.dec1", 251, S_CRUISE, 0);
    for (int i = 1; i <= 62; i++) step();
    expect_out("bnd.dec63", 3, S_CRUISE, 0);
    step(); expect_out("bnd.floor", 0, S_CRUISE, 0);

    // Test 5: async reset mid-BRAKING
    req_speed = 8'd60; limit_speed = 8'd40;
    for (int i = 1; i <= 20; i++) step();
    expect_out("t5.at40", 40, S_CRUISE, 0);
    brake = 1'b1;
    step(); step();
    expect_out("t5.at20", 20, S_BRAKING, 1);
    #3;
    rst = 1'b1;
    #1;
    expect_out("t5.async", 0, S_CRUISE, 0);
    step();
    expect_out("t5.held", 0, S_CRUISE, 0);
    @(negedge clk);
    brake = 1'b0;
    rst = 1'b0;
    step(); expect_out("t5.resume", 2, S_CRUISE, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
